// File: rtl/run_ctrl_pkg.sv
// Shared run-control definitions: state encodings and the enabled-state helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package run_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD   = 2'd0,
    ST_HALTED = 2'd1,
    ST_RUN    = 2'd2,
    ST_STEP   = 2'd3
  } run_state_t;

  // The core clock is enabled only while running freely or stepping.
  function automatic logic is_enabled(input run_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable saturating down-counter with zero flag.
// Latency: load/decrement visible one cycle after the request edge.
// Backpressure: none; decrement at zero holds at zero (never wraps).
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control for the core: stretched core reset, run/halt/N-cycle step/breakpoint halt.
// Latency: all outputs registered; a request sampled at an edge takes effect from that edge.
// Backpressure: none; requests are single-cycle pulses and are dropped when not applicable.
// Optional: define CYCLE_CNT_EN to add the 32-bit enabled-cycle counter port cycle_cnt.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int STEP_W     = 16,
  parameter int AUTO_RUN   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic              ebreak,
  output logic              core_rst,
  output logic              cpu_en,
  output logic [STATE_W-1:0] state,
  output logic              step_done,
  output logic              brk_hit
`ifdef CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);

  // Hold counter only needs to represent RST_CYCLES-1.
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_t        state_q, state_d;
  logic              core_rst_q, cpu_en_q, step_done_q, brk_q;
  logic              done_d, brk_d;

  logic              hold_dec, hold_zero;
  logic [HOLD_W-1:0] hold_val;
  logic              hold_val_unused;

  logic              step_load, step_dec, step_zero;
  logic [STEP_W-1:0] step_load_val;
  logic [STEP_W-1:0] step_rem;

  // Hold counter is reloaded by rst and counts down the post-reset hold window.
  down_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .load     (rst),
    .load_val (HOLD_W'(RST_CYCLES - 1)),
    .dec      (hold_dec),
    .value    (hold_val),
    .zero     (hold_zero)
  );

  // Only the zero flag of the hold counter drives behaviour.
  assign hold_val_unused = ^hold_val;

  // Step counter holds the remaining enabled cycles of a step; rst clears it.
  down_counter #(.WIDTH(STEP_W)) u_step_cnt (
    .clk      (clk),
    .load     (rst | step_load),
    .load_val (rst ? '0 : step_load_val),
    .dec      (step_dec & ~rst),
    .value    (step_rem),
    .zero     (step_zero)
  );

  // Next-state and next-output decode; priority halt_req > ebreak > step_req > run_req.
  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    brk_d         = brk_q;
    hold_dec      = 1'b0;
    step_load     = 1'b0;
    step_load_val = '0;
    step_dec      = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (hold_zero) begin
          state_d = (AUTO_RUN != 0) ? ST_RUN : ST_HALTED;
        end else begin
          hold_dec = 1'b1;
        end
      end
      ST_HALTED: begin
        // ebreak has no meaning while the core is stopped.
        if (!halt_req) begin
          if (step_req && (step_count != '0)) begin
            state_d       = ST_STEP;
            step_load     = 1'b1;
            step_load_val = step_count;
            brk_d         = 1'b0;
          end else if (run_req) begin
            state_d = ST_RUN;
            brk_d   = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (ebreak) begin
          state_d = ST_HALTED;
          brk_d   = 1'b1;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          state_d   = ST_HALTED;
          step_load = 1'b1;
        end else if (ebreak) begin
          state_d   = ST_HALTED;
          step_load = 1'b1;
          brk_d     = 1'b1;
        end else if (step_zero) begin
          // Defensive: a step is never entered with zero remaining.
          state_d = ST_HALTED;
        end else begin
          step_dec = 1'b1;
          if (step_rem == STEP_W'(1)) begin
            state_d = ST_HALTED;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // State and output registers; outputs follow the next state so they align with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      core_rst_q  <= 1'b1;
      cpu_en_q    <= 1'b0;
      step_done_q <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_rst_q  <= (state_d == ST_HOLD);
      cpu_en_q    <= is_enabled(state_d);
      step_done_q <= done_d;
      brk_q       <= brk_d;
    end
  end

`ifdef CYCLE_CNT_EN
  // Count every cycle the core clock is enabled; wraps naturally, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cpu_en_q) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  assign core_rst  = core_rst_q;
  assign cpu_en    = cpu_en_q;
  assign state     = state_q;
  assign step_done = step_done_q;
  assign brk_hit   = brk_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset hold, step, run/halt, breakpoint and abort cases.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit after next posedge.
// Backpressure: n/a.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        run_req, halt_req, step_req, ebreak;
  logic [15:0] step_count;
  logic        core_rst, cpu_en, step_done, brk_hit;
  logic [1:0]  state;
`ifdef CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] c0;
`endif

  int checks = 0;
  int errors = 0;
  int en_cnt;

  cpu_run_ctrl #(.RST_CYCLES(4), .STEP_W(16), .AUTO_RUN(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .step_count (step_count),
    .ebreak     (ebreak),
    .core_rst   (core_rst),
    .cpu_en     (cpu_en),
    .state      (state),
    .step_done  (step_done),
    .brk_hit    (brk_hit)
`ifdef CYCLE_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; ebreak = 1'b0;
    step_count = 16'd0;
    #1;
    tick(); tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_brk_hit", 32'(brk_hit), 32'd0);
`ifdef CYCLE_CNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
`endif

    // Release reset with run_req held: HOLD must ignore it for 4 cycles.
    rst = 1'b0; run_req = 1'b1;
    tick(); chk("hold1_core_rst", 32'(core_rst), 32'd1);
    tick(); chk("hold2_core_rst", 32'(core_rst), 32'd1);
    tick(); chk("hold3_core_rst", 32'(core_rst), 32'd1);
    chk("hold3_state", 32'(state), 32'd0);
    tick();
    run_req = 1'b0;
    chk("hold_exit_state", 32'(state), 32'd1);
    chk("hold_exit_core_rst", 32'(core_rst), 32'd0);
    chk("hold_exit_cpu_en", 32'(cpu_en), 32'd0);
    tick(); chk("halted_idle_state", 32'(state), 32'd1);

    // Step 5 cycles.
`ifdef CYCLE_CNT_EN
    c0 = cycle_cnt;
`endif
    step_count = 16'd5; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("step5_state", 32'(state), 32'd3);
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_en) en_cnt++;
      if (step_done) break;
      tick();
    end
    chk("step5_en_cycles", 32'(en_cnt), 32'd5);
    chk("step5_done", 32'(step_done), 32'd1);
    chk("step5_state_end", 32'(state), 32'd1);
`ifdef CYCLE_CNT_EN
    chk("step5_cycle_cnt", cycle_cnt - c0, 32'd5);
`endif
    tick(); chk("step5_done_pulse", 32'(step_done), 32'd0);

    // Run, then halt 10 cycles later.
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("run_state", 32'(state), 32'd2);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_en) en_cnt++;
      if (i < 9) tick();
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("run10_en_cycles", 32'(en_cnt), 32'd10);
    chk("halt_cpu_en", 32'(cpu_en), 32'd0);
    chk("halt_state", 32'(state), 32'd1);

    // Breakpoint while running.
    run_req = 1'b1; tick(); run_req = 1'b0;
    ebreak = 1'b1; tick(); ebreak = 1'b0;
    chk("ebreak_state", 32'(state), 32'd1);
    chk("ebreak_brk_hit", 32'(brk_hit), 32'd1);
    chk("ebreak_cpu_en", 32'(cpu_en), 32'd0);
    tick(); chk("brk_sticky", 32'(brk_hit), 32'd1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("rerun_state", 32'(state), 32'd2);
    chk("rerun_brk_clear", 32'(brk_hit), 32'd0);
    halt_req = 1'b1; tick(); halt_req = 1'b0;

    // step_req and run_req together: step wins.
    step_count = 16'd2; step_req = 1'b1; run_req = 1'b1;
    tick();
    step_req = 1'b0; run_req = 1'b0;
    chk("steprun_state1", 32'(state), 32'd3);
    tick(); chk("steprun_state2", 32'(state), 32'd3);
    tick();
    chk("steprun_end_state", 32'(state), 32'd1);
    chk("steprun_done", 32'(step_done), 32'd1);

    // step_count = 0 is ignored.
    step_count = 16'd0; step_req = 1'b1; tick(); step_req = 1'b0;
    chk("step0_state", 32'(state), 32'd1);
    chk("step0_cpu_en", 32'(cpu_en), 32'd0);

    // halt on step cycle 2 of 3: no step_done, remaining cleared.
    step_count = 16'd3; step_req = 1'b1; tick(); step_req = 1'b0;
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("stephalt_state", 32'(state), 32'd1);
    chk("stephalt_done", 32'(step_done), 32'd0);
    chk("stephalt_rem", 32'(dut.step_rem), 32'd0);
    tick(); chk("stephalt_done_late", 32'(step_done), 32'd0);

    // ebreak on the final step cycle.
    step_count = 16'd1; step_req = 1'b1; tick(); step_req = 1'b0;
    chk("stepbrk_state", 32'(state), 32'd3);
    ebreak = 1'b1; tick(); ebreak = 1'b0;
    chk("stepbrk_state_end", 32'(state), 32'd1);
    chk("stepbrk_brk_hit", 32'(brk_hit), 32'd1);
    chk("stepbrk_done", 32'(step_done), 32'd0);

    // Maximum step count loads without wrapping.
    step_count = 16'hFFFF; step_req = 1'b1; tick(); step_req = 1'b0;
    chk("stepmax_rem", 32'(dut.step_rem), 32'h0000_FFFF);
    chk("stepmax_brk_clear", 32'(brk_hit), 32'd0);
    tick(); chk("stepmax_rem_dec", 32'(dut.step_rem), 32'h0000_FFFE);
    halt_req = 1'b1; tick(); halt_req = 1'b0;

    // Reset mid-step with remaining = 7.
    step_count = 16'd10; step_req = 1'b1; tick(); step_req = 1'b0;
    tick(); tick(); tick();
    chk("midstep_rem", 32'(dut.step_rem), 32'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_cpu_en", 32'(cpu_en), 32'd0);
    chk("midrst_rem", 32'(dut.step_rem), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
`ifdef CYCLE_CNT_EN
    chk("midrst_cycle_cnt", cycle_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
